// File: rtl/display_pkg.sv
// Shared definitions for the count display: segment codes, converter FSM states,
// anode slot patterns and small helpers used by the converter and the top level.
// No ports; pure constants/functions, zero latency, no flow control.
package display_pkg;

    // Converter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Number of double-dabble iterations for an 8-bit input.
    localparam int BCD_STEPS = 8;

    // Active-low segment codes, ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode patterns per scan slot; an[0] is the rightmost digit.
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_HUNS = 4'b1011;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Scan slot indices.
    localparam logic [1:0] SLOT_ONES  = 2'd0;
    localparam logic [1:0] SLOT_TENS  = 2'd1;
    localparam logic [1:0] SLOT_HUNS  = 2'd2;

    // BCD digit to active-low segments; non-decimal nibbles show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the next doubling, so pre-add 3 to carry into the next digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per cycle).
// Latency: start edge + 8 shift cycles, then one DONE cycle with done=1; busy while not idle.
// Backpressure: none; start is honoured only in IDLE, caller must wait for busy=0.
// Ports: clock, reset (async, active-high), start, bin[7:0] in;
//        busy, done (high for the single DONE cycle), bcd[11:0] {hun,ten,one} out.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t r_state;
    conv_state_t w_state_nxt;

    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;

    logic [11:0] w_adj;
    logic [19:0] w_shifted;
    logic        w_last_step;

    // Correct every nibble, then shift the combined {bcd, bin} register left.
    assign w_adj       = {dabble_adj(r_bcd[11:8]), dabble_adj(r_bcd[7:4]), dabble_adj(r_bcd[3:0])};
    assign w_shifted   = {w_adj[10:0], r_bin, 1'b0};
    assign w_last_step = (r_cnt == 3'(BCD_STEPS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_step) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin <= bin;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_shifted[19:8];
                    r_bin <= w_shifted[7:0];
                    r_cnt <= r_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign bcd  = r_bcd;

endmodule

// File: rtl/count_display.sv
// Shows the 8-bit counter value as decimal 000-255 on a 4-digit multiplexed
// common-anode seven-segment display, with optional leading-zero blanking.
// Latency: DATA sampled at IDLE edge k, display/bcd_valid update at edge k+9; no backpressure
// (DATA is re-compared against the shown value whenever the converter is idle).
// Ports: clock, reset (async, active-high), DATA[7:0] in;
//        seg[6:0] {g..a} active-low, an[3:0] active-low (an[0]=ones), dp (always 1),
//        bcd_valid (one-cycle pulse on display register update) out.
module count_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] DATA,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       bcd_valid
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    // Converter handshake.
    logic        w_busy;
    logic        w_done;
    logic [11:0] w_bcd;
    logic        w_start;

    // Display state.
    logic [7:0]  r_shown;
    logic [7:0]  r_pending;
    logic [3:0]  r_hun;
    logic [3:0]  r_ten;
    logic [3:0]  r_one;
    logic        r_bcd_valid;

    // Scan state and registered pins.
    logic [RW-1:0] r_refresh;
    logic [1:0]    r_slot;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic        w_tc;
    logic [1:0]  w_slot_nxt;
    logic [3:0]  w_hun_nxt;
    logic [3:0]  w_ten_nxt;
    logic [3:0]  w_one_nxt;
    logic [6:0]  w_seg_nxt;
    logic [3:0]  w_an_nxt;

    // A new conversion starts only from IDLE and only when the value differs
    // from what is on the display, so a held DATA costs no conversions.
    assign w_start = !w_busy && (DATA != r_shown);

    bin2bcd_seq u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (w_start),
        .bin   (DATA),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shown     <= '0;
            r_pending   <= '0;
            r_hun       <= '0;
            r_ten       <= '0;
            r_one       <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= w_done;
            if (w_start) begin
                r_pending <= DATA;
            end
            if (w_done) begin
                r_hun   <= w_bcd[11:8];
                r_ten   <= w_bcd[7:4];
                r_one   <= w_bcd[3:0];
                r_shown <= r_pending;
            end
        end
    end

    // Refresh divider: each slot is held for REFRESH_DIV cycles.
    assign w_tc       = (r_refresh == REFRESH_LAST);
    assign w_slot_nxt = w_tc ? (r_slot + 2'd1) : r_slot;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_slot    <= SLOT_ONES;
        end else begin
            r_refresh <= w_tc ? '0 : (r_refresh + RW'(1));
            r_slot    <= w_slot_nxt;
        end
    end

    // Pins are driven from registers, so the decode below looks at the values
    // the digit and slot registers are about to take; that way seg/an change
    // on the same edge as the slot advance or the display update.
    assign w_hun_nxt = w_done ? w_bcd[11:8] : r_hun;
    assign w_ten_nxt = w_done ? w_bcd[7:4]  : r_ten;
    assign w_one_nxt = w_done ? w_bcd[3:0]  : r_one;

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        case (w_slot_nxt)
            SLOT_ONES: begin
                w_an_nxt  = AN_ONES;
                w_seg_nxt = seg_decode(w_one_nxt);
            end
            SLOT_TENS: begin
                if (!(BLANK_LEADING && (w_hun_nxt == 4'd0) && (w_ten_nxt == 4'd0))) begin
                    w_an_nxt  = AN_TENS;
                    w_seg_nxt = seg_decode(w_ten_nxt);
                end
            end
            SLOT_HUNS: begin
                if (!(BLANK_LEADING && (w_hun_nxt == 4'd0))) begin
                    w_an_nxt  = AN_HUNS;
                    w_seg_nxt = seg_decode(w_hun_nxt);
                end
            end
            default: ; // fourth slot is always dark
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_0;
            r_an  <= AN_ONES;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign dp        = 1'b1;
    assign bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_count_display.sv
module tb_count_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] DATA  = 8'd0;

    logic [6:0] seg1, seg0;
    logic [3:0] an1, an0;
    logic       dp1, dp0, v1, v0;

    count_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
        .clock(clock), .reset(reset), .DATA(DATA),
        .seg(seg1), .an(an1), .dp(dp1), .bcd_valid(v1)
    );

    count_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut0 (
        .clock(clock), .reset(reset), .DATA(DATA),
        .seg(seg0), .an(an0), .dp(dp0), .bcd_valid(v0)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d <= 4'd9) ? tbl[d] : 7'b1111111;
    endfunction

    // Monitor: every bcd_valid pulse must match the oldest expected conversion.
    always @(negedge clock) begin
        if (!reset && v1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("valid_cycle", cyc, mon_e.due);
                chk("hun", dut.r_hun, mon_e.h);
                chk("ten", dut.r_ten, mon_e.t);
                chk("one", dut.r_one, mon_e.o);
                chk("dut0_valid", v0, 1'b1);
            end
        end
    end

    // Drive a value just after an edge; it is sampled at the next edge and
    // the pulse is expected 9 edges after that.
    task automatic send(input logic [7:0] v, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        @(posedge clock);
        #1;
        DATA = v;
        sb.push_back('{h, t, o, cyc + 10});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    // Align to the first cycle of the ones slot, then check 16 cycles of scan
    // for both blanking modes.
    task automatic check_scan(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        logic [3:0]  prev;
        logic [10:0] e1, e0;
        int          n;
        bit          found;
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            prev = an1;
            @(negedge clock);
            n++;
            found = (an1 == 4'b1110) && (prev != 4'b1110);
        end
        chk("scan_sync", found, 1'b1);
        for (int j = 0; j < 16; j++) begin
            case (j / 4)
                0: begin
                    e0 = {4'b1110, seg_of(o)};
                    e1 = e0;
                end
                1: begin
                    e0 = {4'b1101, seg_of(t)};
                    e1 = (h == 4'd0 && t == 4'd0) ? 11'h7ff : e0;
                end
                2: begin
                    e0 = {4'b1011, seg_of(h)};
                    e1 = (h == 4'd0) ? 11'h7ff : e0;
                end
                default: begin
                    e0 = 11'h7ff;
                    e1 = 11'h7ff;
                end
            endcase
            chk($sformatf("scan_blank1_%0d%0d%0d_c%0d", h, t, o, j), {an1, seg1}, e1);
            chk($sformatf("scan_blank0_%0d%0d%0d_c%0d", h, t, o, j), {an0, seg0}, e0);
            @(negedge clock);
        end
    endtask

    initial begin
        // Reset with DATA=0.
        reset = 1'b1;
        DATA  = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_an", an1, 4'b1110);
        chk("rst_seg", seg1, 7'b1000000);
        chk("rst_dp", dp1, 1'b1);
        chk("rst_valid", v1, 1'b0);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        chk("idle_an", an1, 4'b1110);
        chk("idle_seg", seg1, 7'b1000000);

        // Full-scale value; hundreds nonzero so the whole scan order is visible.
        send(8'd255, 4'd2, 4'd5, 4'd5);
        wait_drain("c255");
        check_scan(4'd2, 4'd5, 4'd5);

        // Single digit: leading zeros blanked in dut, shown in dut0.
        send(8'd7, 4'd0, 4'd0, 4'd7);
        wait_drain("c7");
        check_scan(4'd0, 4'd0, 4'd7);

        // Zero ones digit with a tens digit.
        send(8'd10, 4'd0, 4'd1, 4'd0);
        wait_drain("c10");
        check_scan(4'd0, 4'd1, 4'd0);

        // Embedded zero tens must stay lit when hundreds is nonzero.
        send(8'd200, 4'd2, 4'd0, 4'd0);
        wait_drain("c200");
        check_scan(4'd2, 4'd0, 4'd0);

        // Back to zero.
        send(8'd0, 4'd0, 4'd0, 4'd0);
        wait_drain("c0");

        // DATA changes during the 3rd shift cycle: 100 completes first, then 42
        // is sampled on the first idle edge and lands 10 cycles later.
        send(8'd100, 4'd1, 4'd0, 4'd0);
        repeat (3) @(posedge clock);
        #1;
        DATA = 8'd42;
        sb.push_back('{4'd0, 4'd4, 4'd2, cyc + 17});
        wait_drain("mid");
        check_scan(4'd0, 4'd4, 4'd2);

        // Reset mid-conversion aborts with no pulse and a zero display.
        @(posedge clock);
        #1;
        DATA = 8'd200;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_an", an1, 4'b1110);
        chk("abort_seg", seg1, 7'b1000000);
        chk("abort_valid", v1, 1'b0);
        chk("abort_dp", dp1, 1'b1);
        DATA = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (30) @(negedge clock);
        chk("abort_no_pending", sb.size(), 0);
        check_scan(4'd0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
